exu_alu_sequencer: RTL and testbench
====================================

Name: exu_alu_sequencer

Overview:
- Execute-stage front end that issues operand/control to the ALU, then consumes its result and flags (of/zf/nf/cf).
- Accepts one decoded operation at a time from IDU via valid/ready.
- Sequences one ALU pass for arithmetic/logic ops, or two ALU passes for conditional branches: compare, then target add.
- Returns result, branch decision and error to WBU via valid/ready.

Parameters:
- WIDTH, 32, datapath width. Must equal the ALU width; only 32 is supported.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  IDU offers an op.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- in_is_br  input  1  1 = conditional branch, 0 = ALU op.
- in_aluop  input  2  ALU op select: 00 add, 01 sub, 10 xor, 11 or.
- in_use_imm  input  1  ALU op: operand b = in_imm instead of in_src2.
- in_funct3  input  3  branch condition, RISC-V encoding.
- in_src1  input  WIDTH  operand rs1.
- in_src2  input  WIDTH  operand rs2.
- in_imm  input  WIDTH  immediate.
- in_pc  input  WIDTH  instruction PC.
- alu_a  output  WIDTH  ALU operand a.
- alu_b  output  WIDTH  ALU operand b.
- alu_ctl  output  3  ALU control.
- alu_result  input  WIDTH  ALU result.
- alu_of  input  1  ALU signed overflow.
- alu_zf  input  1  ALU zero flag.
- alu_nf  input  1  ALU negative flag.
- alu_cf  input  1  ALU carry out; for sub, 1 means a >= b unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  WBU accepts.
- out_result  output  WIDTH  ALU result, or branch target.
- out_br_taken  output  1  branch condition true.
- out_err  output  1  illegal funct3 on a branch.

Behaviour:
- FSM states: IDLE, EXEC, CMP, TGT, DONE. The ALU is combinational; every capture happens at the edge that ends the state.
- Reset (any state, including mid-op): state IDLE; out_valid, out_br_taken, out_err = 0; out_result = 0; all latched operand registers = 0. An in-flight op is dropped with no output.
- IDLE:
  - in_ready = 1; alu_a = alu_b = 0, alu_ctl = 000.
  - On in_valid: latch all in_* fields, then go to CMP if in_is_br, else EXEC.
- EXEC:
  - alu_a = src1; alu_b = use_imm ? imm : src2; alu_ctl = {0, aluop}.
  - At the edge: out_result <= alu_result; out_br_taken <= 0; out_err <= 0; go to DONE.
- CMP:
  - alu_a = src1; alu_b = src2; alu_ctl = 001.
  - At the edge, latch taken:
    - 000 beq: zf
    - 001 bne: ~zf
    - 100 blt: nf ^ of
    - 101 bge: ~(nf ^ of)
    - 110 bltu: ~cf
    - 111 bgeu: cf
    - 010, 011: taken = 0 and out_err <= 1.
  - Go to TGT.
- TGT:
  - alu_a = pc; alu_b = imm; alu_ctl = 000.
  - At the edge: out_result <= alu_result (wraps mod 2^WIDTH; carry ignored); out_br_taken <= latched taken; go to DONE.
- DONE:
  - out_valid = 1; all out_* stay stable until handshake.
  - On out_ready: go to IDLE.
  - in_ready stays 0 throughout, so there is no same-cycle accept.
- Latency, counting edges after the input handshake edge:
  - ALU op: out_valid is high after 1 edge.
  - Branch: out_valid is high after 2 edges.
  - Minimum spacing between accepted ops: ALU 3 cycles, branch 4 cycles.
- alu_ctl never takes values 1xx.
- in_* are ignored outside IDLE.

Test Plan:
- ALU op, aluop=00, src1=0x7FFFFFFF, use_imm=1, imm=1, out_ready=1 -> out_result=0x80000000, out_br_taken=0, out_valid one cycle, next accept 3 cycles after first.
- ALU op, aluop=10, src1=0xF0F0F0F0, src2=0xFF00FF00 -> out_result=0x0FF00FF0. Also aluop=11 with the same operands -> out_result=0xFFF0FFF0.
- Branch blt, src1=0x80000000, src2=1, pc=0x80000100, imm=0xFFFFFFF0 -> taken=1 (overflow case, of=1, nf=0), out_result=0x800000F0, out_valid 2 edges after accept.
- Branches on src1=0xFFFFFFFF, src2=1:
  - bltu -> taken=0.
  - bgeu -> taken=1.
  - bge -> taken=0.
  - beq with src1=src2=5 -> taken=1.
  - bne with src1=src2=5 -> taken=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0, a new in_valid is not accepted. Release -> IDLE, then accept.
- Illegal funct3=010 -> out_err=1, taken=0. Separately, assert rst during TGT -> next cycle IDLE, out_valid=0, all outputs zero, no output produced for the dropped op.

Source files
------------

// File: rtl/exu_alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exu_alu_sequencer : issues ALU passes for ALU ops (one) and branches (two)
// Rev 1.0
// ----------------------------------------------------------------------------
module exu_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_br,
  input  logic [1:0]       in_aluop,
  input  logic             in_use_imm,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_of,
  input  logic             alu_zf,
  input  logic             alu_nf,
  input  logic             alu_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_br_taken,
  output logic             out_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    CMP  = 3'd2,
    TGT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]       r_aluop;
  logic             r_use_imm;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_pc;
  logic             r_taken;

  logic             w_cond;
  logic             w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctl   = 3'b000;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = in_is_br ? CMP : EXEC;
        end
      end
      EXEC: begin
        alu_a    = r_src1;
        alu_b    = r_use_imm ? r_imm : r_src2;
        alu_ctl  = {1'b0, r_aluop};
        state_nx = DONE;
      end
      CMP: begin
        alu_a    = r_src1;
        alu_b    = r_src2;
        alu_ctl  = 3'b001;
        state_nx = TGT;
      end
      TGT: begin
        alu_a    = r_pc;
        alu_b    = r_imm;
        alu_ctl  = 3'b000;
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Branch condition from the flags of the compare (a - b) pass.
  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (r_funct3)
      3'b000:  w_cond = alu_zf;
      3'b001:  w_cond = ~alu_zf;
      3'b100:  w_cond = alu_nf ^ alu_of;
      3'b101:  w_cond = ~(alu_nf ^ alu_of);
      3'b110:  w_cond = ~alu_cf;
      3'b111:  w_cond = alu_cf;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluop      <= '0;
      r_use_imm    <= 1'b0;
      r_funct3     <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_taken      <= 1'b0;
      out_result   <= '0;
      out_br_taken <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_aluop   <= in_aluop;
            r_use_imm <= in_use_imm;
            r_funct3  <= in_funct3;
            r_src1    <= in_src1;
            r_src2    <= in_src2;
            r_imm     <= in_imm;
            r_pc      <= in_pc;
          end
        end
        EXEC: begin
          out_result   <= alu_result;
          out_br_taken <= 1'b0;
          out_err      <= 1'b0;
        end
        CMP: begin
          r_taken <= w_cond & ~w_illegal;
          out_err <= w_illegal;
        end
        TGT: begin
          out_result   <= alu_result;
          out_br_taken <= r_taken;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exu_alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_exu_alu_sequencer : scoreboard bench with a behavioural ALU attached
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_exu_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_br;
  logic [1:0]  in_aluop;
  logic        in_use_imm;
  logic [2:0]  in_funct3;
  logic [31:0] in_src1, in_src2, in_imm, in_pc;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_result;
  logic        alu_of, alu_zf, alu_nf, alu_cf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_br_taken;
  logic        out_err;

  typedef struct packed {
    logic [31:0] res;
    logic        taken;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;

  exu_alu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_br(in_is_br),
    .in_aluop(in_aluop), .in_use_imm(in_use_imm), .in_funct3(in_funct3),
    .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_of(alu_of), .alu_zf(alu_zf),
    .alu_nf(alu_nf), .alu_cf(alu_cf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_br_taken(out_br_taken), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational ALU; cf on sub is the no-borrow carry.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_of     = 1'b0;
    alu_cf     = 1'b0;
    case (alu_ctl)
      3'b000: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[31:0];
        alu_cf     = alu_sum[32];
        alu_of     = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      3'b001: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = alu_sum[31:0];
        alu_cf     = alu_sum[32];
        alu_of     = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      3'b010:  alu_result = alu_a ^ alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zf = (alu_result == 32'd0);
    alu_nf = alu_result[31];
  end

  function automatic exp_t model(input logic br, input logic [1:0] op, input logic ui,
                                 input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] im, input logic [31:0] p);
    exp_t x;
    logic [31:0] b;
    x = '0;
    if (!br) begin
      b = ui ? im : s2;
      case (op)
        2'b00: x.res = s1 + b;
        2'b01: x.res = s1 - b;
        2'b10: x.res = s1 ^ b;
        default: x.res = s1 | b;
      endcase
    end else begin
      x.res = p + im;
      case (f3)
        3'b000: x.taken = (s1 == s2);
        3'b001: x.taken = (s1 != s2);
        3'b100: x.taken = ($signed(s1) < $signed(s2));
        3'b101: x.taken = ($signed(s1) >= $signed(s2));
        3'b110: x.taken = (s1 < s2);
        3'b111: x.taken = (s1 >= s2);
        default: x.err = 1'b1;
      endcase
    end
    return x;
  endfunction

  task automatic send(input logic br, input logic [1:0] op, input logic ui, input logic [2:0] f3,
                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] im,
                      input logic [31:0] p);
    int n;
    n = 0;
    in_is_br = br; in_aluop = op; in_use_imm = ui; in_funct3 = f3;
    in_src1 = s1; in_src2 = s2; in_imm = im; in_pc = p;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout in_ready=%b want=1", in_ready);
      in_valid = 1'b0;
    end else begin
      q.push_back(model(br, op, ui, f3, s1, s2, im, p));
      @(posedge clk); #1;
      accept_cyc = cyc;
      in_valid = 1'b0;
      // Latched copies must be used from here on, not the live inputs.
      in_src1 = $urandom; in_src2 = $urandom; in_imm = $urandom; in_pc = $urandom;
      in_aluop = 2'($urandom); in_use_imm = ~ui; in_funct3 = ~f3;
    end
  endtask

  task automatic collect(output logic [31:0] r, output logic t, output logic e,
                         output int lat, output exp_t x);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL out_valid_timeout out_valid=%b want=1", out_valid);
    end
    r = out_result; t = out_br_taken; e = out_err;
    lat = cyc - accept_cyc;
    if (q.size() > 0) begin
      x = q.pop_front();
    end else begin
      x = '0;
      total++; bad++;
      $display("FAIL scoreboard_empty size=0 want>0");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_is_br = 1'b0; in_aluop = '0; in_use_imm = 1'b0; in_funct3 = '0;
    in_src1 = '0; in_src2 = '0; in_imm = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 ||
        out_br_taken !== 1'b0 || out_err !== 1'b0 || alu_ctl !== 3'b000 ||
        alu_a !== 32'd0 || alu_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_state rdy=%b v=%b res=%h tk=%b err=%b ctl=%b a=%h b=%h want 1 0 0 0 0 000 0 0",
               in_ready, out_valid, out_result, out_br_taken, out_err, alu_ctl, alu_a, alu_b);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] r; logic t, e; int lat, first; exp_t x;
    logic [1:0]  ops [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic        uis [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] s1s [4] = '{32'h7FFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000003};
    logic [31:0] s2s [4] = '{32'h0, 32'hFF00FF00, 32'hFF00FF00, 32'h55555555};
    logic [31:0] ims [4] = '{32'h1, 32'h12345678, 32'h12345678, 32'h00000005};
    out_ready = 1'b1;
    first = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, ops[i], uis[i], 3'b000, s1s[i], s2s[i], ims[i], 32'h0);
      total++;
      if (alu_a !== s1s[i] || alu_b !== (uis[i] ? ims[i] : s2s[i]) || alu_ctl !== {1'b0, ops[i]}) begin
        bad++;
        $display("FAIL exec_operands[%0d] a=%h b=%h ctl=%b want a=%h b=%h ctl=%b", i, alu_a, alu_b,
                 alu_ctl, s1s[i], uis[i] ? ims[i] : s2s[i], {1'b0, ops[i]});
      end
      if (i == 1) begin
        total++;
        if (accept_cyc - first !== 3) begin
          bad++;
          $display("FAIL alu_spacing got=%0d want=3", accept_cyc - first);
        end
      end
      first = accept_cyc;
      collect(r, t, e, lat, x);
      total++;
      if (r !== x.res || t !== x.taken || e !== x.err || lat !== 1) begin
        bad++;
        $display("FAIL alu_op[%0d] res=%h tk=%b err=%b lat=%0d want res=%h tk=%b err=%b lat=1",
                 i, r, t, e, lat, x.res, x.taken, x.err);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL alu_valid_one_cycle[%0d] out_valid=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_branches();
    logic [31:0] r; logic t, e; int lat, prev; exp_t x;
    logic [2:0]  f3s [8] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] s1s [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd5, 32'd5, 32'd5, 32'd9};
    logic [31:0] s2s [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd9};
    logic [31:0] pcs [8] = '{32'h80000100, 32'h00001000, 32'hFFFFFFF8, 32'h00000400,
                             32'h00000200, 32'h00000300, 32'h00000040, 32'h00000080};
    logic [31:0] ims [8] = '{32'hFFFFFFF0, 32'h00000010, 32'h00000010, 32'hFFFFFC00,
                             32'h00000008, 32'h0000000C, 32'h00000004, 32'hFFFFFF80};
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 2'b00, 1'b0, f3s[i], s1s[i], s2s[i], ims[i], pcs[i]);
      total++;
      if (alu_a !== s1s[i] || alu_b !== s2s[i] || alu_ctl !== 3'b001) begin
        bad++;
        $display("FAIL cmp_operands[%0d] a=%h b=%h ctl=%b want a=%h b=%h ctl=001",
                 i, alu_a, alu_b, alu_ctl, s1s[i], s2s[i]);
      end
      if (i > 0) begin
        total++;
        if (accept_cyc - prev !== 4) begin
          bad++;
          $display("FAIL br_spacing[%0d] got=%0d want=4", i, accept_cyc - prev);
        end
      end
      prev = accept_cyc;
      collect(r, t, e, lat, x);
      total++;
      if (r !== x.res || t !== x.taken || e !== x.err || lat !== 2) begin
        bad++;
        $display("FAIL branch[%0d] f3=%b res=%h tk=%b err=%b lat=%0d want res=%h tk=%b err=%b lat=2",
                 i, f3s[i], r, t, e, lat, x.res, x.taken, x.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic t, e; int lat; exp_t x; int stable_bad;
    out_ready = 1'b0;
    send(1'b1, 2'b00, 1'b0, 3'b001, 32'd4, 32'd7, 32'h00000020, 32'h00001000);
    collect(r, t, e, lat, x);
    total++;
    if (r !== x.res || t !== x.taken || e !== x.err) begin
      bad++;
      $display("FAIL bp_result res=%h tk=%b err=%b want res=%h tk=%b err=%b",
               r, t, e, x.res, x.taken, x.err);
    end
    in_valid = 1'b1; in_is_br = 1'b0; in_aluop = 2'b11;
    in_src1 = 32'hAAAAAAAA; in_src2 = 32'h55555555;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== r || out_br_taken !== t ||
          out_err !== e || in_ready !== 1'b0) stable_bad++;
    end
    total++;
    if (stable_bad != 0) begin
      bad++;
      $display("FAIL bp_stable bad_cycles=%0d want=0 (v=%b res=%h rdy=%b)",
               stable_bad, out_valid, out_result, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_ignored_op out_valid=%b want=0", out_valid);
    end
    send(1'b0, 2'b01, 1'b0, 3'b000, 32'd10, 32'd20, 32'd0, 32'd0);
    collect(r, t, e, lat, x);
    total++;
    if (r !== x.res || t !== x.taken || e !== x.err || lat !== 1) begin
      bad++;
      $display("FAIL bp_after res=%h tk=%b err=%b lat=%0d want res=%h tk=%b err=%b lat=1",
               r, t, e, lat, x.res, x.taken, x.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic t, e; int lat; exp_t x; int seen;
    out_ready = 1'b1;
    send(1'b1, 2'b00, 1'b0, 3'b000, 32'd3, 32'd3, 32'h00000010, 32'h12340000);
    @(posedge clk); #1;
    total++;
    if (alu_a !== 32'h12340000 || alu_b !== 32'h00000010 || alu_ctl !== 3'b000) begin
      bad++;
      $display("FAIL tgt_operands a=%h b=%h ctl=%b want a=12340000 b=00000010 ctl=000",
               alu_a, alu_b, alu_ctl);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (q.size() > 0) void'(q.pop_back());
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 ||
        out_br_taken !== 1'b0 || out_err !== 1'b0 || alu_a !== 32'd0 ||
        alu_b !== 32'd0 || alu_ctl !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset rdy=%b v=%b res=%h tk=%b err=%b a=%h b=%h ctl=%b want 1 0 0 0 0 0 0 000",
               in_ready, out_valid, out_result, out_br_taken, out_err, alu_a, alu_b, alu_ctl);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL dropped_op_output valid_cycles=%0d want=0", seen);
    end
    send(1'b0, 2'b00, 1'b1, 3'b000, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0);
    collect(r, t, e, lat, x);
    total++;
    if (r !== x.res || t !== x.taken || e !== x.err || lat !== 1) begin
      bad++;
      $display("FAIL post_reset_op res=%h tk=%b err=%b lat=%0d want res=%h tk=%b err=%b lat=1",
               r, t, e, lat, x.res, x.taken, x.err);
    end
    @(posedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover size=%0d want=0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branches();
    test_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
